uart_tx_128to8: RTL and testbench



---
 rtl/uart_tx_128to8.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_128to8.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_128to8.sv
// uart_tx_128to8
// ---------------------------------------------------------------------------
// Serializes 128-bit words into 16 UART bytes (8N1, LSB first on the wire).
// The first byte sent is din[127:120] and the last is din[7:0], which mirrors
// the byte order of the bit8to128 receive path. Frame-buffer readback data
// from the DDR3 read FIFO is returned to the host through this block.
//
// Parameters:
//   BAUD_DIV  sclk cycles per UART bit (2..65535)
//   BYTE_NUM  bytes per input word (16 for a 128-bit din)
//
// Ports:
//   sclk       system clock, rising edge
//   rst_n      asynchronous active-low reset
//   din        word to transmit, sampled only on accept
//   din_valid  din holds a valid word
//   din_ready  block can accept a word (high only in IDLE)
//   tx         UART serial line, idle high
//   busy       high from the accept cycle until the last stop bit ends
//   tx_done    one-cycle pulse when the final stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_128to8 #(
    parameter int BAUD_DIV = 5208,
    parameter int BYTE_NUM = 16
) (
    input  logic         sclk,
    input  logic         rst_n,
    input  logic [127:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         tx,
    output logic         busy,
    output logic         tx_done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  BYTE_LAST = 4'(BYTE_NUM - 1);

    state_t         state, state_nxt;
    logic [15:0]    baud_cnt, baud_cnt_nxt;
    logic [2:0]     bit_cnt, bit_cnt_nxt;
    logic [3:0]     byte_cnt, byte_cnt_nxt;
    logic [127:0]   sreg, sreg_nxt;
    logic [7:0]     cur_byte_nxt;
    logic           baud_end;
    logic           tx_nxt;
    logic           din_ready_nxt;
    logic           busy_nxt;
    logic           tx_done_nxt;

    assign baud_end = (baud_cnt == BAUD_LAST);

    // State, counters, shift register and all outputs are registered here.
    // The outputs are computed from the next state so that they change on
    // the same edge as the state itself, e.g. tx drops on the accept edge.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            sreg      <= '0;
            tx        <= 1'b1;
            din_ready <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            byte_cnt  <= byte_cnt_nxt;
            sreg      <= sreg_nxt;
            tx        <= tx_nxt;
            din_ready <= din_ready_nxt;
            busy      <= busy_nxt;
            tx_done   <= tx_done_nxt;
        end
    end

    // Next-state logic. Every level on the line lasts exactly BAUD_DIV
    // cycles: baud_cnt runs 0..BAUD_DIV-1 and restarts on each bit or state
    // change. After a stop bit the next byte's start bit follows with no gap.
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_cnt_nxt  = bit_cnt;
        byte_cnt_nxt = byte_cnt;
        sreg_nxt     = sreg;
        tx_done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (din_valid) begin
                    sreg_nxt     = din;
                    state_nxt    = START;
                    baud_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                    byte_cnt_nxt = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_nxt    = DATA;
                    baud_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_cnt_nxt = '0;
                    if (byte_cnt == BYTE_LAST) begin
                        state_nxt    = IDLE;
                        byte_cnt_nxt = '0;
                        tx_done_nxt  = 1'b1;
                    end else begin
                        state_nxt    = START;
                        byte_cnt_nxt = byte_cnt + 4'd1;
                        sreg_nxt     = {sreg[119:0], 8'h00};
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // The byte on the wire is always the top byte of the shift register.
        cur_byte_nxt = sreg_nxt[127:120];

        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = cur_byte_nxt[bit_cnt_nxt];
            default: tx_nxt = 1'b1;
        endcase

        din_ready_nxt = (state_nxt == IDLE);
        busy_nxt      = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_128to8.sv
// tb_uart_tx_128to8
// ---------------------------------------------------------------------------
// Self-checking bench for uart_tx_128to8 with BAUD_DIV=4. A UART monitor
// decodes every frame on tx, insists each level is stable for its full bit
// time, and compares each byte against a queue of expected bytes pushed when
// a word is driven. A table of words covers the main function; hand-written
// sequences cover bit timing, back-to-back words, ignored input while busy
// and reset in the middle of a word.
// ---------------------------------------------------------------------------
module tb_uart_tx_128to8;

    localparam int B        = 4;
    localparam int WORD_CYC = 160 * B;

    logic         sclk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         tx;
    logic         busy;
    logic         tx_done;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int done_count = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];

    typedef struct {
        logic [127:0] din;
        logic [7:0]   first_byte;
        logic [7:0]   last_byte;
    } vec_t;

    vec_t vecs[4];

    uart_tx_128to8 #(
        .BAUD_DIV(B),
        .BYTE_NUM(16)
    ) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 sclk = ~sclk;

    // Cycle counter: after each rising edge it holds the number of edges seen.
    initial begin
        forever begin
            @(posedge sclk);
            cyc++;
        end
    end

    // Count tx_done pulses on the falling edge.
    initial begin
        forever begin
            @(negedge sclk);
            if (tx_done === 1'b1) done_count++;
        end
    end

    task automatic check_output(input string name, input logic [127:0] act,
                                input logic [127:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic timeout_fail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // UART monitor sampling on the falling edge, away from the DUT's edge.
    initial begin
        bit         mon_active;
        int         mon_idx;
        int         slot;
        int         pos;
        logic       mon_level;
        logic [7:0] mon_byte;
        logic       mon_err;
        logic [7:0] e;
        mon_active = 1'b0;
        mon_idx    = 0;
        mon_level  = 1'b0;
        mon_byte   = '0;
        mon_err    = 1'b0;
        forever begin
            @(negedge sclk);
            if (rst_n !== 1'b1) begin
                mon_active = 1'b0;
                exp_q.delete();
            end else if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_idx    = 1;
                    mon_level  = 1'b0;
                    mon_err    = 1'b0;
                    mon_byte   = '0;
                end
            end else begin
                slot = mon_idx / B;
                pos  = mon_idx % B;
                if (pos == 0) begin
                    mon_level = tx;
                    if (slot >= 1 && slot <= 8) mon_byte[3'(slot - 1)] = tx;
                    else if (slot == 9 && tx !== 1'b1) mon_err = 1'b1;
                end else if (tx !== mon_level) begin
                    mon_err = 1'b1;
                end
                mon_idx++;
                if (mon_idx == 10 * B) begin
                    mon_active = 1'b0;
                    rx_log.push_back(mon_byte);
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_byte: got %0h expected none", mon_byte);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("rx_byte(framing_err,byte)",
                                     {119'b0, mon_err, mon_byte}, {120'b0, e});
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [127:0] w);
        for (int k = 0; k < 16; k++) exp_q.push_back(w[127 - 8 * k -: 8]);
    endtask

    // Waits for din_ready, drives one word and returns just after the accept
    // edge with the cycle number of that edge.
    task automatic apply_stimulus(input logic [127:0] w, input bit hold,
                                  output int acc);
        int n;
        n = 0;
        while (din_ready !== 1'b1 && n < 2000) begin
            @(posedge sclk);
            #1;
            n++;
        end
        if (din_ready !== 1'b1) timeout_fail("din_ready_wait");
        din       = w;
        din_valid = 1'b1;
        push_word(w);
        @(posedge sclk);
        #1;
        acc = cyc;
        if (!hold) din_valid = 1'b0;
    endtask

    task automatic wait_done(output int done_at, output bit busy_ok);
        done_at = -1;
        busy_ok = 1'b1;
        for (int i = 0; i < 1000 && done_at < 0; i++) begin
            @(posedge sclk);
            #1;
            if (tx_done === 1'b1) done_at = cyc;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        if (done_at < 0) timeout_fail("tx_done_wait");
    endtask

    task automatic send_word(input logic [127:0] w, input logic [7:0] first_b,
                             input logic [7:0] last_b);
        int acc;
        int d;
        bit bok;
        rx_log.delete();
        apply_stimulus(w, 1'b0, acc);
        check_output("tx_low_after_accept", 128'(tx), 128'(0));
        check_output("ready_busy_after_accept", 128'({din_ready, busy}), 128'(2'b01));
        wait_done(d, bok);
        check_output("word_latency", 128'(d - acc), 128'(WORD_CYC));
        check_output("busy_held", 128'(bok), 128'(1));
        check_output("ready_busy_at_done", 128'({din_ready, busy, tx}), 128'(3'b101));
        check_output("byte_count", 128'(rx_log.size()), 128'(16));
        check_output("first_byte", 128'(rx_log[0]), 128'(first_b));
        check_output("last_byte", 128'(rx_log[15]), 128'(last_b));
        check_output("queue_drained", 128'(exp_q.size()), 128'(0));
        @(posedge sclk);
        #1;
        check_output("tx_done_one_cycle", 128'(tx_done), 128'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          acc;
        int          acc1;
        int          d0;
        int          d1;
        int          dc;
        bit          bok;
        bit          stable;
        logic [39:0] cap;
        logic [39:0] expv;
        logic [9:0]  lv;
        logic [7:0]  ab;
        logic [127:0] w0;
        logic [127:0] w1;

        vecs[0] = '{din: 128'h00112233_44556677_8899AABB_CCDDEEFF, first_byte: 8'h00, last_byte: 8'hFF};
        vecs[1] = '{din: 128'hA5000000_00000000_00000000_0000005A, first_byte: 8'hA5, last_byte: 8'h5A};
        vecs[2] = '{din: {128{1'b1}},                              first_byte: 8'hFF, last_byte: 8'hFF};
        vecs[3] = '{din: 128'h80000000_00000000_00000000_00000001, first_byte: 8'h80, last_byte: 8'h01};

        // Reset state and idle stability.
        rst_n = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        check_output("reset_tx", 128'(tx), 128'(1));
        check_output("reset_din_ready", 128'(din_ready), 128'(1));
        check_output("reset_busy", 128'(busy), 128'(0));
        check_output("reset_tx_done", 128'(tx_done), 128'(0));
        rst_n  = 1'b1;
        stable = 1'b1;
        repeat (100) begin
            @(posedge sclk);
            #1;
            if ({tx, din_ready, busy, tx_done} !== 4'b1100) stable = 1'b0;
        end
        check_output("idle_stable", 128'(stable), 128'(1));

        // Table-driven words.
        for (int v = 0; v < 4; v++) begin
            send_word(vecs[v].din, vecs[v].first_byte, vecs[v].last_byte);
        end

        // Bit-level timing of a first byte of A5.
        rx_log.delete();
        ab    = 8'hA5;
        lv[0] = 1'b0;
        for (int k = 0; k < 8; k++) lv[1 + k] = ab[k];
        lv[9] = 1'b1;
        for (int s = 0; s < 10; s++)
            for (int j = 0; j < B; j++) expv[s * B + j] = lv[s];
        apply_stimulus(128'hA5123456_789ABCDE_F0011223_34455667, 1'b0, acc);
        cap[0] = tx;
        for (int i = 1; i < 40; i++) begin
            @(posedge sclk);
            #1;
            cap[i] = tx;
        end
        check_output("a5_bit_sequence", 128'(cap), 128'(expv));
        wait_done(d0, bok);
        check_output("a5_latency", 128'(d0 - acc), 128'(WORD_CYC));

        // Back-to-back words with din_valid held high.
        rx_log.delete();
        w0 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        w1 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        apply_stimulus(w0, 1'b1, acc);
        din = w1;
        push_word(w1);
        wait_done(d0, bok);
        check_output("b2b_first_latency", 128'(d0 - acc), 128'(WORD_CYC));
        check_output("b2b_idle_at_done", 128'({tx, din_ready}), 128'(2'b11));
        @(posedge sclk);
        #1;
        acc1 = cyc;
        din_valid = 1'b0;
        check_output("b2b_second_start", 128'({tx, busy}), 128'(2'b01));
        wait_done(d1, bok);
        check_output("b2b_done_spacing", 128'(d1 - d0), 128'(WORD_CYC + 1));
        check_output("b2b_second_latency", 128'(d1 - acc1), 128'(WORD_CYC));
        check_output("b2b_byte_count", 128'(rx_log.size()), 128'(32));
        check_output("b2b_queue_drained", 128'(exp_q.size()), 128'(0));

        // din_valid pulsed with other data during byte 5 must be ignored.
        rx_log.delete();
        apply_stimulus(128'h11223344_55667788_99AABBCC_DDEEFF00, 1'b0, acc);
        repeat (5 * 10 * B + 10) @(posedge sclk);
        #1;
        din       = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
        din_valid = 1'b1;
        check_output("busy_not_ready", 128'(din_ready), 128'(0));
        repeat (3) @(posedge sclk);
        #1;
        din_valid = 1'b0;
        wait_done(d0, bok);
        check_output("ignore_latency", 128'(d0 - acc), 128'(WORD_CYC));
        check_output("ignore_byte5", 128'(rx_log[5]), 128'(8'h66));
        check_output("ignore_queue_drained", 128'(exp_q.size()), 128'(0));
        @(posedge sclk);
        #1;
        check_output("ignore_no_restart", 128'(busy), 128'(0));

        // Reset asserted during the start bit of byte 7.
        rx_log.delete();
        apply_stimulus(128'h0102030405060708090A0B0C0D0E0F10, 1'b0, acc);
        repeat (7 * 10 * B + 1) @(posedge sclk);
        #1;
        check_output("byte7_start_low", 128'(tx), 128'(0));
        dc    = done_count;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_outputs", 128'({tx, din_ready, busy, tx_done}), 128'(4'b1100));
        repeat (3) @(posedge sclk);
        #1;
        rst_n = 1'b1;
        repeat (400) @(posedge sclk);
        #1;
        check_output("no_done_after_reset", 128'(done_count), 128'(dc));
        check_output("partial_bytes", 128'(rx_log.size()), 128'(7));
        send_word(128'hFEDCBA98_76543210_0F0E0D0C_0B0A0908, 8'hFE, 8'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
